// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_e : arbitration state (CPU-priority normal mode / debug forced)
//   WAIT_W      : width of the debug starvation wait counter
package dmem_arb_pkg;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    ARB_NORMAL  = 1'b0,
    ARB_STARVED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the CPU load/store path, the debug/loader port, dmem
// and the arbiter.
//   cpu_*   : CPU request, store data, load data and stall
//   dbg_*   : debug request/grant, write data, registered read return
//   mem_*   : single dmem port (asynchronous read)
// Modports: master = environment (CPU, debug host, dmem), slave = arbiter.
interface dmem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Debug starvation tracker: counts consecutive cycles in which the debug
// port requests but is denied.
//   clk, reset : clock, synchronous active-high reset
//   dbg_req    : debug request
//   dbg_gnt    : debug granted this cycle
//   last_wait  : this cycle is denial number MAX_WAIT if debug loses now
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic last_wait
);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   cnt_inc;
  logic              denied;

  assign denied    = dbg_req & ~dbg_gnt;
  assign cnt_inc   = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
  // Independent of dbg_gnt so the arbiter can combine it with its own grant
  // without forming a combinational loop.
  assign last_wait = (cnt_inc == (WAIT_W + 1)'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (denied) begin
      wait_cnt <= cnt_inc[WAIT_W-1:0];
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU load/store path has fixed priority over the
// debug/loader port; after MAX_WAIT consecutive debug denials the debug port
// is forced through for one cycle and the CPU is stalled.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arb_if.slave (cpu_*, dbg_*, mem_* signals)
// Optional build macro DMEM_ARB_PERF_EN adds:
//   perf_stall_cnt : saturating count of cycles with cpu_stall=1
//   perf_dbg_cnt   : saturating count of debug grants
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arb_if.slave   bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_dbg_cnt
`endif
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              last_wait;
  logic              dbg_read;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  dmem_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .dbg_req  (bus.dbg_req),
    .dbg_gnt  (dbg_gnt),
    .last_wait(last_wait)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB_NORMAL: begin
          if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (bus.dbg_req) begin
            dbg_gnt = 1'b1;
          end
          if (bus.dbg_req && !dbg_gnt && last_wait) begin
            state_d = ARB_STARVED;
          end
        end
        ARB_STARVED: begin
          if (bus.dbg_req) begin
            dbg_gnt = 1'b1;
          end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
          end
          // Debug is either served now or has withdrawn: one cycle only.
          state_d = ARB_NORMAL;
        end
        default: state_d = ARB_NORMAL;
      endcase
    end
  end

  // Address/data follow the debug port only when it owns the cycle.
  assign addr_mux  = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
  assign wdata_mux = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
  assign dbg_read  = dbg_gnt & ~bus.dbg_we;

  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = bus.cpu_req & dbg_gnt;
  assign bus.dbg_gnt   = dbg_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dbg_read;
      if (dbg_read) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] dbg_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      if (bus.cpu_req && dbg_gnt && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (dbg_gnt && dbg_cnt_q != '1) begin
        dbg_cnt_q <= dbg_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_dbg_cnt   = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: two instances (MAX_WAIT=8 and MAX_WAIT=1),
// each with its own dmem array and a reference model based on counting
// consecutive denied debug cycles.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus, per DUT index
  logic        rst       [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        dbg_req   [2];
  logic        dbg_we    [2];
  logic [31:0] dbg_addr  [2];
  logic [31:0] dbg_wdata [2];

  // observed outputs, per DUT index
  logic        o_gnt   [2];
  logic        o_stall [2];
  logic        o_mwe   [2];
  logic [31:0] o_maddr [2];
  logic [31:0] o_mwd   [2];
  logic [31:0] o_crd   [2];
  logic        o_rv    [2];
  logic [31:0] o_rd    [2];

  // environment memories (16 words each)
  logic [31:0] mem [2][16] = '{default: '0};

  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] ps [2];
  logic [31:0] pd [2];
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8)) dut_a (
    .clk  (clk),
    .reset(rst[0]),
    .bus  (bus_a)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt(ps[0]),
    .perf_dbg_cnt  (pd[0])
`endif
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(1)) dut_b (
    .clk  (clk),
    .reset(rst[1]),
    .bus  (bus_b)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt(ps[1]),
    .perf_dbg_cnt  (pd[1])
`endif
  );

  assign bus_a.cpu_req   = cpu_req[0];
  assign bus_a.cpu_we    = cpu_we[0];
  assign bus_a.cpu_addr  = cpu_addr[0];
  assign bus_a.cpu_wdata = cpu_wdata[0];
  assign bus_a.dbg_req   = dbg_req[0];
  assign bus_a.dbg_we    = dbg_we[0];
  assign bus_a.dbg_addr  = dbg_addr[0];
  assign bus_a.dbg_wdata = dbg_wdata[0];
  assign bus_a.mem_rdata = mem[0][bus_a.mem_addr[5:2]];
  assign bus_b.cpu_req   = cpu_req[1];
  assign bus_b.cpu_we    = cpu_we[1];
  assign bus_b.cpu_addr  = cpu_addr[1];
  assign bus_b.cpu_wdata = cpu_wdata[1];
  assign bus_b.dbg_req   = dbg_req[1];
  assign bus_b.dbg_we    = dbg_we[1];
  assign bus_b.dbg_addr  = dbg_addr[1];
  assign bus_b.dbg_wdata = dbg_wdata[1];
  assign bus_b.mem_rdata = mem[1][bus_b.mem_addr[5:2]];

  assign o_gnt[0]   = bus_a.dbg_gnt;
  assign o_stall[0] = bus_a.cpu_stall;
  assign o_mwe[0]   = bus_a.mem_we;
  assign o_maddr[0] = bus_a.mem_addr;
  assign o_mwd[0]   = bus_a.mem_wdata;
  assign o_crd[0]   = bus_a.cpu_rdata;
  assign o_rv[0]    = bus_a.dbg_rvalid;
  assign o_rd[0]    = bus_a.dbg_rdata;
  assign o_gnt[1]   = bus_b.dbg_gnt;
  assign o_stall[1] = bus_b.cpu_stall;
  assign o_mwe[1]   = bus_b.mem_we;
  assign o_maddr[1] = bus_b.mem_addr;
  assign o_mwd[1]   = bus_b.mem_wdata;
  assign o_crd[1]   = bus_b.cpu_rdata;
  assign o_rv[1]    = bus_b.dbg_rvalid;
  assign o_rd[1]    = bus_b.dbg_rdata;

  always @(posedge clk) begin
    if (bus_a.mem_we === 1'b1) mem[0][bus_a.mem_addr[5:2]] <= bus_a.mem_wdata;
    if (bus_b.mem_we === 1'b1) mem[1][bus_b.mem_addr[5:2]] <= bus_b.mem_wdata;
  end

  // ---------------------------------------------------------------------
  // checking
  // ---------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned mw(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  // reference model state
  int unsigned m_streak [2];   // consecutive cycles debug requested and lost
  logic        m_rvalid [2];
  logic [31:0] m_rdata  [2];
  logic [31:0] shadow   [2][16];
  int unsigned m_pstall [2];
  int unsigned m_pdbg   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_streak[k] = 0;
      m_rvalid[k] = 1'b0;
      m_rdata[k]  = '0;
      m_pstall[k] = 0;
      m_pdbg[k]   = 0;
      for (int w = 0; w < 16; w++) shadow[k][w] = '0;
    end
  end

  task automatic model_check(input int k);
    logic        g_dbg, g_cpu, we;
    logic [31:0] addr, wd;
    string       s;
    s = $sformatf("[%0d]", k);
    if (rst[k]) begin
      g_dbg = 1'b0;
      g_cpu = 1'b0;
    end else begin
      g_dbg = dbg_req[k] && (!cpu_req[k] || m_streak[k] >= mw(k));
      g_cpu = cpu_req[k] && !g_dbg;
    end
    we   = (g_cpu && cpu_we[k]) || (g_dbg && dbg_we[k]);
    addr = g_dbg ? dbg_addr[k]  : cpu_addr[k];
    wd   = g_dbg ? dbg_wdata[k] : cpu_wdata[k];

    chk({"dbg_gnt", s},    64'(o_gnt[k]),   64'(g_dbg));
    chk({"cpu_stall", s},  64'(o_stall[k]), 64'(cpu_req[k] && g_dbg));
    chk({"mem_we", s},     64'(o_mwe[k]),   64'(we));
    chk({"mem_addr", s},   64'(o_maddr[k]), 64'(addr));
    if (we) chk({"mem_wdata", s}, 64'(o_mwd[k]), 64'(wd));
    chk({"cpu_rdata", s},  64'(o_crd[k]),   64'(shadow[k][addr[5:2]]));
    chk({"dbg_rvalid", s}, 64'(o_rv[k]),    64'(m_rvalid[k]));
    chk({"dbg_rdata", s},  64'(o_rd[k]),    64'(m_rdata[k]));
`ifdef DMEM_ARB_PERF_EN
    chk({"perf_stall", s}, 64'(ps[k]),      64'(m_pstall[k]));
    chk({"perf_dbg", s},   64'(pd[k]),      64'(m_pdbg[k]));
`endif

    if (rst[k]) begin
      m_streak[k] = 0;
      m_rvalid[k] = 1'b0;
      m_rdata[k]  = '0;
      m_pstall[k] = 0;
      m_pdbg[k]   = 0;
    end else begin
      m_rvalid[k] = g_dbg && !dbg_we[k];
      if (g_dbg && !dbg_we[k]) m_rdata[k] = shadow[k][dbg_addr[k][5:2]];
      if (dbg_req[k] && !g_dbg) m_streak[k]++;
      else                      m_streak[k] = 0;
      if (cpu_req[k] && g_dbg) m_pstall[k]++;
      if (g_dbg)               m_pdbg[k]++;
      if (we) shadow[k][addr[5:2]] = wd;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) model_check(k);
    end
  end

  // ---------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    cpu_req[k] = 1'b0;
    cpu_we[k]  = 1'b0;
    dbg_req[k] = 1'b0;
    dbg_we[k]  = 1'b0;
  endtask

  initial begin
    int          first_gnt;
    int          stalls;
    int          grants;
    logic [7:0]  pat;
    logic        saw_gnt [2];

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      idle(k);
      cpu_addr[k]  = '0;
      cpu_wdata[k] = '0;
      dbg_addr[k]  = '0;
      dbg_wdata[k] = '0;
      saw_gnt[k]   = 1'b0;
    end

    // reset held while the CPU tries to store
    cpu_req[0]   = 1'b1;
    cpu_we[0]    = 1'b1;
    cpu_addr[0]  = 32'h10;
    cpu_wdata[0] = 32'hAA;
    step();
    chk_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_we", 64'(o_mwe[0]), 64'd0);
      chk("rst_rvalid", 64'(o_rv[0]), 64'd0);
      step();
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("first_store_we", 64'(o_mwe[0]), 64'd1);
    step();
    chk("first_store_mem", 64'(mem[0][4]), 64'hAA);
    idle(0);

    // debug write then read, CPU idle
    dbg_req[0]   = 1'b1;
    dbg_we[0]    = 1'b1;
    dbg_addr[0]  = 32'h4;
    dbg_wdata[0] = 32'd10;
    @(negedge clk);
    chk("dbg_wr_gnt", 64'(o_gnt[0]), 64'd1);
    step();
    dbg_we[0] = 1'b0;
    @(negedge clk);
    chk("dbg_rd_gnt", 64'(o_gnt[0]), 64'd1);
    step();
    dbg_req[0] = 1'b0;
    @(negedge clk);
    chk("dbg_rd_rvalid", 64'(o_rv[0]), 64'd1);
    chk("dbg_rd_data", 64'(o_rd[0]), 64'd10);
    step();

    // continuous contention, MAX_WAIT=8, fresh from reset
    rst[0] = 1'b1;
    step();
    rst[0]      = 1'b0;
    cpu_req[0]  = 1'b1;
    cpu_we[0]   = 1'b0;
    cpu_addr[0] = 32'h20;
    dbg_req[0]  = 1'b1;
    dbg_we[0]   = 1'b0;
    dbg_addr[0] = 32'h8;
    first_gnt = -1;
    stalls    = 0;
    grants    = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (o_gnt[0] === 1'b1) begin
        grants++;
        if (first_gnt < 0) first_gnt = c;
      end
      if (c <= 8 && o_stall[0] === 1'b1) stalls++;
      step();
    end
    chk("starve_first_gnt", 64'(first_gnt), 64'd8);
    chk("starve_stalls_0_8", 64'(stalls), 64'd1);
    chk("starve_grants_36", 64'(grants), 64'd4);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_36", 64'(ps[0]), 64'd4);
    chk("perf_dbg_36", 64'(pd[0]), 64'd4);
`endif
    idle(0);
    step();

    // MAX_WAIT=1: strict alternation
    cpu_req[1]  = 1'b1;
    cpu_addr[1] = 32'h0;
    dbg_req[1]  = 1'b1;
    dbg_addr[1] = 32'h4;
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat[c] = o_stall[1];
      step();
    end
    chk("alt_stall_pattern", 64'(pat), 64'hAA);
    idle(1);

    // same-cycle CPU and debug writes to 0x8
    cpu_req[0]   = 1'b1;
    cpu_we[0]    = 1'b1;
    cpu_addr[0]  = 32'h8;
    cpu_wdata[0] = 32'd3;
    dbg_req[0]   = 1'b1;
    dbg_we[0]    = 1'b1;
    dbg_addr[0]  = 32'h8;
    dbg_wdata[0] = 32'd50;
    @(negedge clk);
    chk("collide_dbg_gnt", 64'(o_gnt[0]), 64'd0);
    step();
    chk("collide_mem_cpu", 64'(mem[0][2]), 64'd3);
    cpu_req[0] = 1'b0;
    @(negedge clk);
    chk("collide_dbg_retry", 64'(o_gnt[0]), 64'd1);
    step();
    chk("collide_mem_dbg", 64'(mem[0][2]), 64'd50);
    idle(0);
    step();

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom_range(499) == 0);
        cpu_req[k]   = (i < 1500) ? ($urandom_range(7) != 0) : ($urandom_range(3) != 0);
        cpu_we[k]    = $urandom_range(1) == 1;
        cpu_addr[k]  = {26'd0, 4'($urandom_range(15)), 2'b00};
        cpu_wdata[k] = $urandom;
        if (!dbg_req[k] || saw_gnt[k]) begin
          dbg_req[k]   = $urandom_range(1) == 1;
          dbg_we[k]    = $urandom_range(1) == 1;
          dbg_addr[k]  = {26'd0, 4'($urandom_range(15)), 2'b00};
          dbg_wdata[k] = $urandom;
        end else if ($urandom_range(63) == 0) begin
          dbg_req[k] = 1'b0;   // tolerated withdrawal
        end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) saw_gnt[k] = (o_gnt[k] === 1'b1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
